vec_lane_packer: RTL and testbench

- Streaming front-end for the 4-lane Q8.8 dot-product datapath.
- Accepts scalar 16-bit Q8.8 elements one per cycle over a valid/ready handshake.
- Packs them into 64-bit 4-lane words in the lane order the dot-product unit unpacks: lane1 in [63:48], lane4 in [15:0].
- Partial trailing words are zero-padded, so unused lanes contribute 0 to the downstream sum.

---
 rtl/vec_lane_packer.sv | 147 ++++++++++++++
 tb/tb_vec_lane_packer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_lane_packer.sv
// Packs a stream of ELEM_W-bit elements into LANES-wide words (lane1 in the top bits).
// A single pending buffer absorbs one completed word while the output register is blocked.
module vec_lane_packer #(
   parameter int ELEM_W = 16,
   parameter int LANES  = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [ELEM_W-1:0]            in_data,
   input  logic                         in_last,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [ELEM_W*LANES-1:0]      out_data,
   output logic                         out_last,
   output logic [$clog2(LANES+1)-1:0]   out_count
);
   localparam int WORD_W = ELEM_W * LANES;
   localparam int CNT_W  = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int CNTO_W = $clog2(LANES + 1);

   typedef enum logic [0:0] {
      FILL  = 1'b0,
      STALL = 1'b1
   } state_t;

   state_t              state_reg, state_next;
   logic                ready_en_reg;
   logic [CNT_W-1:0]    cnt_reg, cnt_next;
   logic [WORD_W-1:0]   fill_reg, fill_next;
   logic                out_valid_reg, out_valid_next;
   logic [WORD_W-1:0]   out_data_reg, out_data_next;
   logic                out_last_reg, out_last_next;
   logic [CNTO_W-1:0]   out_count_reg, out_count_next;
   logic [WORD_W-1:0]   pend_data_reg, pend_data_next;
   logic                pend_last_reg, pend_last_next;
   logic [CNTO_W-1:0]   pend_count_reg, pend_count_next;

   logic                accept;
   logic                drain;
   logic                complete;
   logic [WORD_W-1:0]   word_cur;
   logic [CNTO_W-1:0]   word_count;

   // ready_en_reg keeps in_ready low during reset and until the first edge after release
   assign in_ready   = ready_en_reg && (state_reg == FILL);
   assign accept     = in_valid && in_ready;
   assign drain      = out_valid_reg && out_ready;
   assign complete   = accept && (in_last || (cnt_reg == CNT_W'(LANES - 1)));
   assign word_count = CNTO_W'(cnt_reg) + CNTO_W'(1);

   // Fill buffer with the incoming element dropped into lane cnt; untouched lanes stay zero
   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         assign word_cur[(LANES-1-gi)*ELEM_W +: ELEM_W] =
            (cnt_reg == CNT_W'(gi)) ? in_data : fill_reg[(LANES-1-gi)*ELEM_W +: ELEM_W];
      end
   endgenerate

   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg;
      fill_next       = fill_reg;
      out_valid_next  = out_valid_reg;
      out_data_next   = out_data_reg;
      out_last_next   = out_last_reg;
      out_count_next  = out_count_reg;
      pend_data_next  = pend_data_reg;
      pend_last_next  = pend_last_reg;
      pend_count_next = pend_count_reg;

      if (complete) begin
         cnt_next  = '0;
         fill_next = '0;
      end else if (accept) begin
         cnt_next  = cnt_reg + CNT_W'(1);
         fill_next = word_cur;
      end

      case (state_reg)
         FILL: begin
            if (complete) begin
               if (!out_valid_reg || drain) begin
                  out_valid_next = 1'b1;
                  out_data_next  = word_cur;
                  out_last_next  = in_last;
                  out_count_next = word_count;
               end else begin
                  pend_data_next  = word_cur;
                  pend_last_next  = in_last;
                  pend_count_next = word_count;
                  state_next      = STALL;
               end
            end else if (drain) begin
               out_valid_next = 1'b0;
            end
         end
         STALL: begin
            // No accepts happen here, so only the drain can move things along
            if (drain) begin
               out_valid_next = 1'b1;
               out_data_next  = pend_data_reg;
               out_last_next  = pend_last_reg;
               out_count_next = pend_count_reg;
               state_next     = FILL;
            end
         end
         default: state_next = FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= FILL;
         ready_en_reg   <= 1'b0;
         cnt_reg        <= '0;
         fill_reg       <= '0;
         out_valid_reg  <= 1'b0;
         out_data_reg   <= '0;
         out_last_reg   <= 1'b0;
         out_count_reg  <= '0;
         pend_data_reg  <= '0;
         pend_last_reg  <= 1'b0;
         pend_count_reg <= '0;
      end else begin
         state_reg      <= state_next;
         ready_en_reg   <= 1'b1;
         cnt_reg        <= cnt_next;
         fill_reg       <= fill_next;
         out_valid_reg  <= out_valid_next;
         out_data_reg   <= out_data_next;
         out_last_reg   <= out_last_next;
         out_count_reg  <= out_count_next;
         pend_data_reg  <= pend_data_next;
         pend_last_reg  <= pend_last_next;
         pend_count_reg <= pend_count_next;
      end
   end

   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign out_last  = out_last_reg;
   assign out_count = out_count_reg;

endmodule

// File: tb/tb_vec_lane_packer.sv
// Bench for vec_lane_packer: a queue-based vector model predicts words, a monitor checks them.
module tb_vec_lane_packer;
   localparam int W = 16;
   localparam int L = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid, in_ready, in_last;
   logic [15:0]   in_data;
   logic          out_valid, out_ready, out_last;
   logic [63:0]   out_data;
   logic [2:0]    out_count;

   vec_lane_packer #(.ELEM_W(W), .LANES(L)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .out_count(out_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [63:0] data;
      logic        last;
      logic [2:0]  count;
   } word_t;

   word_t       exp_q[$];
   logic [15:0] cur_q[$];
   int          pop_cyc[$];
   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          stall_cnt = 0;
   bit          rand_or = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [67:0] act, input logic [67:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference: collect elements of the current vector; a word closes at 4 elements or on last
   function automatic void model_accept(input logic [15:0] d, input logic last);
      word_t w;
      cur_q.push_back(d);
      if (last || cur_q.size() == L) begin
         w.data = '0;
         foreach (cur_q[i]) w.data = w.data | (64'(cur_q[i]) << (W * (L - 1 - i)));
         w.last  = last;
         w.count = 3'(cur_q.size());
         exp_q.push_back(w);
         cur_q.delete();
      end
   endfunction

   task automatic send(input logic [15:0] d, input logic last);
      int waited;
      waited = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      forever begin
         @(negedge clk);
         if (in_ready) begin
            model_accept(d, last);
            @(posedge clk); #1;
            break;
         end
         @(posedge clk); #1;
         waited++;
         stall_cnt++;
         if (waited > 300) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: element %h not accepted after %0d cycles", d, waited);
            break;
         end
      end
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_data  = 16'($urandom);
      in_last  = 1'($urandom);
   endtask

   task automatic drain_wait();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain_done", 68'(exp_q.size()), 68'(0));
      repeat (2) @(posedge clk);
      #1;
   endtask

   // Monitor: compares each handshaken word and checks the output holds while blocked
   initial begin
      word_t got;
      word_t held_w;
      word_t e;
      bit    held;
      held = 0;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid) begin
            got = '{out_data, out_last, out_count};
            if (held) check("hold_stable", got, held_w);
            if (out_ready) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_word: got %h required none", got);
               end else begin
                  e = exp_q.pop_front();
                  check("word", got, e);
               end
               pop_cyc.push_back(cyc);
               held = 0;
            end else begin
               held   = 1;
               held_w = got;
            end
         end else begin
            held = 0;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      rst_n     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 68'(in_ready), 68'(0));
      check("rst_out_valid", 68'(out_valid), 68'(0));
      check("rst_out_data", 68'(out_data), 68'(0));
      check("rst_out_last", 68'(out_last), 68'(0));
      check("rst_out_count", 68'(out_count), 68'(0));
      #2 rst_n = 1'b1;
      #1 check("rel_in_ready_low", 68'(in_ready), 68'(0));
      @(posedge clk); #1;
      check("rel_in_ready_high", 68'(in_ready), 68'(1));

      // Full word, one-cycle pulse right after the 4th accept
      send(16'h0100, 0); send(16'h0200, 0); send(16'h0300, 0); send(16'h0400, 0);
      idle();
      check("t1_valid", 68'(out_valid), 68'(1));
      check("t1_data", 68'(out_data), 68'(64'h0100_0200_0300_0400));
      @(posedge clk); #1;
      check("t1_pulse_one", 68'(out_valid), 68'(0));
      drain_wait();

      // Six elements: one full word then a padded word
      for (int i = 1; i <= 6; i++) send(16'(i), i == 6);
      idle();
      drain_wait();

      // Single-element vector
      send(16'hFF80, 1);
      idle();
      drain_wait();

      // Backpressure: two words pile up, the second in the pending buffer
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) send(16'h1000 + 16'(i), 0);
      idle();
      check("bp_in_ready_low", 68'(in_ready), 68'(0));
      check("bp_out_valid", 68'(out_valid), 68'(1));
      repeat (3) @(posedge clk);
      #1;
      pop_cyc.delete();
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_ready_back", 68'(in_ready), 68'(1));
      check("bp_second_valid", 68'(out_valid), 68'(1));
      @(posedge clk); #1;
      check("bp_pops", 68'(pop_cyc.size()), 68'(2));
      if (pop_cyc.size() == 2)
         check("bp_back_to_back", 68'(pop_cyc[1] - pop_cyc[0]), 68'(1));
      drain_wait();

      // Continuous stream, full throughput
      pop_cyc.delete();
      stall_cnt = 0;
      for (int i = 0; i < 12; i++) send(16'($urandom), 0);
      idle();
      drain_wait();
      check("stream_no_stall", 68'(stall_cnt), 68'(0));
      check("stream_pops", 68'(pop_cyc.size()), 68'(3));
      if (pop_cyc.size() == 3) begin
         check("stream_gap1", 68'(pop_cyc[1] - pop_cyc[0]), 68'(4));
         check("stream_gap2", 68'(pop_cyc[2] - pop_cyc[1]), 68'(4));
      end

      // Reset mid-word discards the partial word
      send(16'hDEAD, 0); send(16'hBEEF, 0);
      idle();
      rst_n = 1'b0;
      cur_q.delete();
      #1;
      check("mid_rst_in_ready", 68'(in_ready), 68'(0));
      check("mid_rst_out_valid", 68'(out_valid), 68'(0));
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      pop_cyc.delete();
      send(16'h0A0A, 0); send(16'h0B0B, 0); send(16'h0C0C, 0); send(16'h0D0D, 0);
      idle();
      drain_wait();
      check("mid_rst_one_word", 68'(pop_cyc.size()), 68'(1));

      // Randomized traffic with random backpressure and input gaps
      rand_or = 1;
      fork
         begin
            while (rand_or) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(0, 2) != 0);
            end
            out_ready = 1'b1;
         end
      join_none
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            idle();
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
         send(16'($urandom), (i == 299) || ($urandom_range(0, 4) == 0));
      end
      idle();
      rand_or = 0;
      repeat (3) @(posedge clk);
      #1;
      drain_wait();
      check("model_no_partial", 68'(cur_q.size()), 68'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
